// File: rtl/button_conditioner_if.sv
// Button bundle between the board side (master) and the conditioner (slave):
// raw levels in, debounced level and one-cycle event pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long, btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long, btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button sync + debounce + press/release/long/repeat pulses; BTN_AUTOREPEAT_EN enables repeat.
// Press/release latency DEBOUNCE_CYCLES+2 edges, all outputs registered; no backpressure (pulses are fire-and-forget).
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 15_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT  = HW'(LONG_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_conditioner: cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_e;

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn.btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_e          state_q, state_d;
        logic [DW-1:0]   dcnt_q, dcnt_d;
        logic [HW-1:0]   hcnt_q, hcnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            long_q, long_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                hcnt_q    <= hcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        // hcnt advances on every HELD cycle, including the one where the input drops,
        // so only cycles actually spent in DEB_RELEASE are excluded from the long timer.
        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            hcnt_d  = hcnt_q;
            case (state_q)
                IDLE: begin
                    dcnt_d = '0;
                    if (s2_q[i]) begin
                        state_d = DEB_PRESS;
                        dcnt_d  = DW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (!s2_q[i]) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else if (dcnt_q == D_LAST) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (hcnt_q != H_SAT) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    if (!s2_q[i]) begin
                        state_d = DEB_RELEASE;
                        dcnt_d  = DW'(1);
                    end
                end
                DEB_RELEASE: begin
                    if (s2_q[i]) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                    end else if (dcnt_q == D_LAST) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            level_d   = level_q;
            case (state_q)
                DEB_PRESS: begin
                    if (s2_q[i] && dcnt_q == D_LAST) begin
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end
                end
                HELD: long_d = (hcnt_q == H_LAST);
                DEB_RELEASE: begin
                    if (!s2_q[i] && dcnt_q == D_LAST) begin
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        assign btn.btn_level[i]   = level_q;
        assign btn.btn_press[i]   = press_q;
        assign btn.btn_release[i] = release_q;
        assign btn.btn_long[i]    = long_q;

`ifdef BTN_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES);
        localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          repeat_q, repeat_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                rcnt_q   <= '0;
                repeat_q <= 1'b0;
            end else begin
                rcnt_q   <= rcnt_d;
                repeat_q <= repeat_d;
            end
        end

        // First repeat coincides with the long pulse; the period counter only runs
        // once hcnt has saturated and is frozen outside HELD.
        always_comb begin
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            case (state_q)
                IDLE: rcnt_d = '0;
                HELD: begin
                    if (hcnt_q == H_LAST) begin
                        rcnt_d   = '0;
                        repeat_d = 1'b1;
                    end else if (hcnt_q == H_SAT) begin
                        if (rcnt_q == R_LAST) begin
                            rcnt_d   = '0;
                            repeat_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        assign btn.btn_repeat[i] = repeat_q;
`else
        assign btn.btn_repeat[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench: directed scenarios with literal timing plus randomized levels against a run-length model.
module tb_button_conditioner;

    localparam int NB   = 5;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(NB)) bus ();

    button_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level flips after DEB consecutive synchronised samples disagree with it;
    // hold time counts edges where the button is accepted-high and no release debounce is running.
    bit        m_s1 [NB];
    bit        m_s2 [NB];
    bit        m_lvl[NB];
    int        m_run[NB];
    int        m_held[NB];
    bit [NB-1:0] e_level, e_press, e_release, e_long, e_repeat;

    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_held[b] = 0;
            end
            e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        end else begin
            e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
            for (int b = 0; b < NB; b++) begin
                if (m_lvl[b] && m_run[b] == 0) begin
                    m_held[b]++;
                    if (m_held[b] == LONG) e_long[b] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    if (m_held[b] >= LONG && (m_held[b] - LONG) % REP == 0) e_repeat[b] = 1'b1;
`endif
                end
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        if (m_lvl[b]) begin
                            e_press[b] = 1'b1;
                            m_held[b]  = 0;
                        end else begin
                            e_release[b] = 1'b1;
                        end
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = bus.btn_raw[b];
                e_level[b] = m_lvl[b];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_level",   bus.btn_level,   e_level);
            check("model_press",   bus.btn_press,   e_press);
            check("model_release", bus.btn_release, e_release);
            check("model_long",    bus.btn_long,    e_long);
            check("model_repeat",  bus.btn_repeat,  e_repeat);
        end
    end

    task automatic wait_press(input logic [NB-1:0] mask, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((bus.btn_press & mask) != '0) seen = 1;
        end
        check(name, seen, 1);
    endtask

    initial begin
        int pat[6] = '{1, 1, 0, 1, 1, 0};
        logic [NB-1:0] acc;
        logic [63:0] rep_mask, rep_exp;
        int long_n, long_k;
        int rem[NB];

        bus.btn_raw = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_level",   bus.btn_level,   0);
        check("reset_press",   bus.btn_press,   0);
        check("reset_release", bus.btn_release, 0);
        check("reset_long",    bus.btn_long,    0);
        check("reset_repeat",  bus.btn_repeat,  0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press and release of bit 0
        bus.btn_raw[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("clean_press_time", bus.btn_press, (i == 6) ? 5'b00001 : 5'b00000);
        end
        check("clean_level_high", bus.btn_level, 5'b00001);
        repeat (3) @(negedge clk);
        bus.btn_raw[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("clean_release_time", bus.btn_release, (i == 6) ? 5'b00001 : 5'b00000);
        end
        check("clean_level_low", bus.btn_level, 5'b00000);
        repeat (4) @(negedge clk);

        // Bounce rejection on bit 1
        acc = '0;
        for (int j = 0; j < 40; j++) begin
            bus.btn_raw[1] = pat[j % 6][0];
            @(negedge clk);
            acc |= bus.btn_press | bus.btn_release | bus.btn_long | bus.btn_level;
        end
        bus.btn_raw[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            acc |= bus.btn_press | bus.btn_release | bus.btn_long | bus.btn_level;
        end
        check("bounce_no_events", acc, 0);

        // Long press and auto-repeat on bit 2
        bus.btn_raw[2] = 1'b1;
        wait_press(5'b00100, "long_press_seen");
        long_n = 0; long_k = -1; rep_mask = '0; acc = '0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (bus.btn_long[2]) begin long_n++; long_k = k; end
            if (bus.btn_repeat[2]) rep_mask |= (64'd1 << k);
            acc |= bus.btn_press | bus.btn_release;
        end
        check("long_count", long_n, 1);
        check("long_delay", long_k, 20);
        check("long_no_press_release", acc, 0);
`ifdef BTN_AUTOREPEAT_EN
        rep_exp = (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 36) | (64'd1 << 44);
`else
        rep_exp = '0;
`endif
        check("repeat_pattern", rep_mask, rep_exp);
        bus.btn_raw[2] = 1'b0;
        repeat (10) @(negedge clk);

        // Short release glitch during HELD on bit 4
        bus.btn_raw[4] = 1'b1;
        wait_press(5'b10000, "glitch_press_seen");
        long_n = 0; long_k = -1; acc = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.btn_long[4]) begin long_n++; long_k = k; end
            acc |= bus.btn_press | bus.btn_release;
            if (k == 10) bus.btn_raw[4] = 1'b0;
            if (k == 12) bus.btn_raw[4] = 1'b1;
        end
        check("glitch_no_press_release", acc, 0);
        check("glitch_long_count", long_n, 1);
        check("glitch_long_delay", long_k, 22);
        bus.btn_raw[4] = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous press on bits 0 and 3, then reset while held
        bus.btn_raw = 5'b01001;
        wait_press(5'b01001, "simul_press_seen");
        check("simul_press_same_cycle", bus.btn_press, 5'b01001);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_level",   bus.btn_level,   0);
        check("midreset_release", bus.btn_release, 0);
        check("midreset_long",    bus.btn_long,    0);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("postreset_press_time", bus.btn_press, (i == 6) ? 5'b01001 : 5'b00000);
            check("postreset_no_release", bus.btn_release, 0);
        end
        bus.btn_raw = '0;
        repeat (10) @(negedge clk);

        // Randomized levels with mixed bounce and long holds, occasional reset
        for (int b = 0; b < NB; b++) rem[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    bus.btn_raw[b] = ~bus.btn_raw[b];
                    rem[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 70))
                                                         : int'($urandom_range(1, 6));
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        bus.btn_raw = '0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
